// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive framer.
// No logic of its own; the parameter check is evaluated at elaboration.
// No flow control.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // XOR of up to 9 data bits; narrower words are zero-extended by the caller.
    function automatic logic parity_of(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Legal configuration: 5..9 data bits, even bit period of at least 4 clocks,
    // 1 or 2 stop bits, parity mode none/odd/even.
    function automatic bit params_ok(input int data_bits, input int clks_per_bit,
                                     input int parity, input int stop_bits);
        return (data_bits >= 5) && (data_bits <= 9) &&
               (clks_per_bit >= 4) && ((clks_per_bit % 2) == 0) &&
               (stop_bits == 1 || stop_bits == 2) &&
               (parity >= PARITY_NONE) && (parity <= PARITY_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input, resets to idle-high.
// Latency: 2 clk cycles.
// No flow control.
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the raw line through two stages.
    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    // Synchroniser registers, reset to the idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start qualification, centre sampling, parity/stop checks, output holding register.
// Latency: data_valid rises 1 clk after the last stop-bit sample.
// Backpressure: one-word holding register; a frame completing while it is full and not accepted is dropped with an overrun pulse.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    if (!params_ok(DATA_BITS, CLKS_PER_BIT, PARITY, STOP_BITS)) begin : g_param_check
        $error("uart_rx_frame: illegal parameter combination");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    logic rx_s;

    rx_sync u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s)
    );

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_nxt_q, perr_nxt_d;
    logic                 ferr_nxt_q, ferr_nxt_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 ferr_final;

    // Next-state, bit timer, shift register and holding-register update.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        perr_nxt_d   = perr_nxt_q;
        ferr_nxt_d   = ferr_nxt_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        ferr_final   = ferr_nxt_q | ~rx_s;

        // A transfer empties the holding register; a completing frame below may refill it.
        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    perr_nxt_d = 1'b0;
                    ferr_nxt_d = 1'b0;
                    // A line that is high again at mid-start was only a glitch.
                    state_d    = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d      = '0;
                    perr_nxt_d = (parity_of(9'(shift_q)) ^ rx_s) != (PARITY == PARITY_ODD);
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d      = '0;
                    ferr_nxt_d = ferr_final;
                    if (bit_q == LAST_STOP) begin
                        bit_d = '0;
                        if (!data_valid_q || data_ready) begin
                            data_d       = shift_q;
                            parity_err_d = perr_nxt_q;
                            frame_err_d  = ferr_final;
                            data_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        // All-zero data with a low final stop bit is a line break.
                        state_d = ((shift_q == '0) && !rx_s) ? ST_BREAK : ST_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            perr_nxt_q   <= 1'b0;
            ferr_nxt_q   <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            perr_nxt_q   <= perr_nxt_d;
            ferr_nxt_q   <= ferr_nxt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
